// File: rtl/proc_pkg.sv
//============================================================================
// Module      : proc_pkg
// Description : Shared processor constants. Holds the default address and
//               instruction widths, the opcode encodings and the fetch-stage
//               state type.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package proc_pkg;

    // Default widths: 16-word program space, 16-bit instructions
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_INST_W = 16;

    // Opcodes occupy the top four bits of an instruction
    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    // Fetch stage states
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage : proc_pkg

`default_nettype wire

// File: rtl/pc_counter.sv
//============================================================================
// Module      : pc_counter
// Description : Program counter register. Load has priority over increment;
//               increment wraps modulo 2^ADDR_W; otherwise the value holds.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pc_counter #(
    parameter int                ADDR_W   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Next-PC selection: load, then increment (natural wrap), else hold
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // PC register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule : pc_counter

`default_nettype wire

// File: rtl/instruction_fetch.sv
//============================================================================
// Module      : instruction_fetch
// Description : Fetch stage. Owns the PC, addresses the combinational
//               program ROM and registers the returned instruction into a
//               valid/ready output slot for decode. Handles redirects from
//               execute and parks in HALT after fetching a HALT opcode.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module instruction_fetch
    import proc_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_addr,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted
);

    fetch_state_e      state_d,      state_q;
    logic              inst_valid_d, inst_valid_q;
    logic [INST_W-1:0] inst_d,       inst_q;
    logic [ADDR_W-1:0] inst_pc_d,    inst_pc_q;
    logic              halted_d,     halted_q;

    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic              pc_inc;
    logic              slot_free;
    logic              fetch_fire;
    logic              fetch_is_halt;

    // Output slot can take a new instruction when empty or being drained
    assign slot_free     = !inst_valid_q || inst_ready;
    assign fetch_fire    = (state_q == RUN) && en && slot_free && !redir_valid;
    assign fetch_is_halt = (rom_inst[INST_W-1 -: 4] == OP_HALT);

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .load_addr (redir_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    // The ROM address is the PC with nothing in between
    assign rom_addr = pc;

    // Next-state logic: redirect beats everything, then fetch, then drain
    always_comb begin
        state_d      = state_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        halted_d     = halted_q;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;

        if (redir_valid) begin
            // Flush the slot even if decode is accepting this cycle
            pc_load      = 1'b1;
            inst_valid_d = 1'b0;
            state_d      = RUN;
            halted_d     = 1'b0;
        end else if (fetch_fire) begin
            inst_d       = rom_inst;
            inst_pc_d    = pc;
            inst_valid_d = 1'b1;
            if (fetch_is_halt) begin
                // PC stays on the HALT word so rom_addr parks there
                state_d  = HALT;
                halted_d = 1'b1;
            end else begin
                pc_inc = 1'b1;
            end
        end else if (slot_free) begin
            // No new fetch; an accepted instruction leaves the slot empty
            inst_valid_d = 1'b0;
        end
    end

    // Fetch state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            halted_q     <= halted_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign halted     = halted_q;

endmodule : instruction_fetch

`default_nettype wire
